// File: rtl/ram_rd_pkg.sv
// ram_rd_pkg: shared definitions for the RAM row reader.
//   rd_state_t     : sweep FSM state encoding (IDLE, READ, DRAIN)
//   DEF_ROWS/COLS  : default RAM geometry
//   addr_w()       : address width helper, never returns less than 1 bit
package ram_rd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } rd_state_t;

   localparam int DEF_ROWS = 4;
   localparam int DEF_COLS = 32;

   // Width of an address that selects one of n items.
   function automatic int addr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ram_rd_skid_fifo.sv
// ram_rd_skid_fifo: 2-entry FIFO that absorbs the RAM read latency so the
// reader can stream at one beat per cycle under backpressure.
//   clk, rst : clock, asynchronous active-high reset
//   push,din : write one entry (ignored when full)
//   pop      : drop the head entry (ignored when empty)
//   dout     : head entry, zero while empty after reset
//   empty    : no entries held
//   count    : number of entries held (0..2)
module ram_rd_skid_fifo
   import ram_rd_pkg::*;
#(
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == 2'd0);
   assign do_push = push && (count != 2'd2);
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ram_row_reader.sv
// ram_row_reader: sweeps one RAM row (columns 0..COLS-1) through a
// registered 1-cycle-latency read port and streams it out.
//   clk, rst          : clock, asynchronous active-high reset
//   start, row_sel    : request a sweep of row_sel (taken only when idle)
//   busy, done        : sweep in progress / one-cycle completion pulse
//   r_row, r_col      : RAM read address, ram_dout: RAM read data
//   m_valid, m_ready, m_data, m_last : output stream
//   state_dbg         : current FSM state for observation
//
// Stream handshake: a beat transfers on every rising edge where m_valid
// and m_ready are both high; once m_valid rises, m_valid, m_data and
// m_last stay unchanged until that transfer happens.
module ram_row_reader
   import ram_rd_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ROWS       = DEF_ROWS,
   parameter int COLS       = DEF_COLS,
   localparam int RW        = addr_w(ROWS),
   localparam int CW        = addr_w(COLS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [RW-1:0]         row_sel,
   output logic                  busy,
   output logic                  done,
   output logic [RW-1:0]         r_row,
   output logic [CW-1:0]         r_col,
   input  logic [DATA_WIDTH-1:0] ram_dout,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic [1:0]            state_dbg
);

   rd_state_t         state;
   logic              inflight;       // a read was issued last cycle
   logic              inflight_last;  // ... and it was column COLS-1
   logic              issue;
   logic              pop;
   logic              last_col;
   logic              row_ok;
   logic              fifo_empty;
   logic [1:0]        occ;
   logic [1:0]        pending;
   logic [DATA_WIDTH:0] head;

   assign state_dbg = state;
   assign busy      = (state != IDLE);
   assign m_valid   = !fifo_empty;
   assign pop       = m_valid && m_ready;
   assign {m_last, m_data} = head;
   assign last_col  = (r_col == CW'(COLS - 1));
   assign row_ok    = ({1'b0, row_sel} < (RW + 1)'(ROWS));

   // Entries buffered plus the one still coming out of the RAM. Issuing is
   // safe whenever that total stays within the 2 buffer slots after this
   // cycle's pop, which is what gives one beat per cycle without overflow.
   assign pending = occ + {1'b0, inflight};

   always_comb begin
      issue = 1'b0;
      if (state == READ) begin
         if (pending < 2'd2) begin
            issue = 1'b1;
         end else if (pending == 2'd2 && pop) begin
            issue = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         r_row         <= '0;
         r_col         <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         done          <= 1'b0;
      end else begin
         inflight      <= issue;
         inflight_last <= issue && last_col;
         done          <= 1'b0;
         case (state)
            IDLE: begin
               if (start && row_ok) begin
                  r_row <= row_sel;
                  r_col <= '0;
                  state <= READ;
               end
            end
            READ: begin
               if (issue) begin
                  // Column COLS-1 is held rather than wrapped so the address
                  // never strays into a neighbouring row.
                  if (last_col) begin
                     state <= DRAIN;
                  end else begin
                     r_col <= r_col + CW'(1);
                  end
               end
            end
            DRAIN: begin
               if (pop && m_last) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   ram_rd_skid_fifo #(
      .WIDTH (DATA_WIDTH + 1)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (inflight),
      .din   ({inflight_last, ram_dout}),
      .pop   (pop),
      .dout  (head),
      .empty (fifo_empty),
      .count (occ)
   );

endmodule

// File: tb/tb_ram_row_reader.sv
module tb_ram_row_reader;

   localparam int DW   = 8;
   localparam int ROWS = 4;
   localparam int COLS = 32;
   localparam int RW   = 2;
   localparam int CW   = 5;

   // clock / reset
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          start;
   logic [RW-1:0] row_sel;
   logic          busy, done;
   logic [RW-1:0] r_row;
   logic [CW-1:0] r_col;
   logic [DW-1:0] ram_dout;
   logic          m_valid, m_ready, m_last;
   logic [DW-1:0] m_data;
   logic [1:0]    state_dbg;

   ram_row_reader #(.DATA_WIDTH(DW), .ROWS(ROWS), .COLS(COLS)) dut (
      .clk(clk), .rst(rst), .start(start), .row_sel(row_sel),
      .busy(busy), .done(done), .r_row(r_row), .r_col(r_col),
      .ram_dout(ram_dout), .m_valid(m_valid), .m_ready(m_ready),
      .m_data(m_data), .m_last(m_last), .state_dbg(state_dbg)
   );

   // RAM with registered read port
   logic [DW-1:0] mem [ROWS][COLS];
   always @(posedge clk) ram_dout <= mem[r_row][r_col];

   // scoreboard state
   logic [DW:0] exp_q[$];
   logic [DW:0] e;
   int n_vec = 0;
   int n_err = 0;
   int beats = 0;
   int done_cnt = 0;
   bit sweep_active = 0;
   bit last_hs_prev = 0;
   bit prev_stall = 0;
   logic [DW-1:0] prev_data;
   logic prev_last;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: an accepted sweep yields the whole row in column order.
   task automatic do_start(input int row);
      start   = 1'b1;
      row_sel = RW'(row);
      if (!sweep_active) begin
         for (int c = 0; c < COLS; c++) exp_q.push_back({(c == COLS - 1), mem[row][c]});
         sweep_active = 1;
      end
      tick();
      start = 1'b0;
   endtask

   // Run until the model sees the final beat; returns in the done cycle.
   task automatic run_stream(input bit rnd);
      int n;
      n = 0;
      while (sweep_active && n < 2000) begin
         m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         tick();
         n++;
      end
      check("stream_timeout", 32'(n < 2000), 1);
      check("done_cycle_done", done, 1);
      check("done_cycle_busy", busy, 0);
      check("queue_empty", exp_q.size(), 0);
      m_ready = 1'b1;
   endtask

   // monitor
   always @(negedge clk) begin
      if (rst) begin
         prev_stall   = 0;
         last_hs_prev = 0;
      end else begin
         bit hs_last;
         hs_last = 0;
         check("done_pulse", done, 32'(last_hs_prev));
         if (done === 1'b1) begin
            done_cnt++;
            check("busy_in_done", busy, 0);
         end
         if (prev_stall) begin
            check("stall_valid", m_valid, 1);
            check("stall_data", m_data, prev_data);
            check("stall_last", m_last, prev_last);
         end
         if (!sweep_active) check("idle_valid", m_valid, 0);
         if (m_valid === 1'b1 && m_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("extra_beat", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("beat_data", m_data, e[DW-1:0]);
               check("beat_last", m_last, e[DW]);
               beats++;
               if (e[DW]) begin
                  sweep_active = 0;
                  hs_last = 1;
               end
            end
         end
         last_hs_prev = hs_last;
         prev_stall   = (m_valid === 1'b1) && (m_ready === 1'b0);
         prev_data    = m_data;
         prev_last    = m_last;
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_valid"}, m_valid, 0);
      check({tag, "_last"}, m_last, 0);
      check({tag, "_data"}, m_data, 0);
      check({tag, "_row"}, r_row, 0);
      check({tag, "_col"}, r_col, 0);
   endtask

   initial begin
      int n, dc, b0;
      rst = 1'b1; start = 1'b0; row_sel = '0; m_ready = 1'b0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            mem[r][c] = (r == 2) ? DW'(8'h40 + c) : DW'($urandom);
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();

      // full-rate sweep of row 2 with latency check
      m_ready = 1'b1;
      do_start(2);
      check("lat_c1_valid", m_valid, 0);
      tick();
      check("lat_c2_valid", m_valid, 0);
      tick();
      check("lat_c3_valid", m_valid, 1);
      check("lat_c3_data", m_data, 8'h40);
      dc = done_cnt;
      run_stream(0);
      tick();
      check("t1_done_count", done_cnt - dc, 1);

      // random backpressure on row 2
      do_start(2);
      run_stream(1);
      tick();

      // long stall after start
      m_ready = 1'b0;
      do_start(2);
      repeat (20) tick();
      check("stall_issues", 32'(r_col <= 5'd2), 1);
      check("stall_hold_valid", m_valid, 1);
      check("stall_hold_data", m_data, 8'h40);
      run_stream(1);
      tick();

      // start while busy is ignored
      m_ready = 1'b1;
      dc = done_cnt;
      do_start(3);
      repeat (5) tick();
      do_start(1);
      check("ignored_row", r_row, 3);
      run_stream(1);
      repeat (3) tick();
      check("t4_done_count", done_cnt - dc, 1);

      // reset mid-sweep after 10 beats of row 0
      b0 = beats;
      dc = done_cnt;
      do_start(0);
      n = 0;
      while (beats - b0 < 10 && n < 200) begin tick(); n++; end
      check("rst_wait_timeout", 32'(n < 200), 1);
      #2;
      rst = 1'b1;
      exp_q.delete();
      sweep_active = 0;
      #1;
      check_reset_outputs("midrst");
      tick();
      tick();
      rst = 1'b0;
      repeat (4) tick();
      check("midrst_no_done", done_cnt - dc, 0);
      do_start(0);
      run_stream(0);
      tick();

      // start in the done cycle
      do_start(1);
      run_stream(0);
      do_start(3);
      check("b2b_busy", busy, 1);
      check("b2b_row", r_row, 3);
      run_stream(1);
      repeat (2) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
